// File: rtl/sdram_timing_pkg.sv
// Shared definitions for the SDRAM timing monitor: bank state encoding,
// picosecond-to-clock conversion and counter-width helpers.
package sdram_timing_pkg;

  typedef enum logic {
    BANK_IDLE = 1'b0,
    BANK_OPEN = 1'b1
  } bank_state_e;

  localparam int CREDIT_W = 4;

  // Clocks needed to cover t_ps, rounded up, never below one.
  function automatic int ps_to_clk(input longint t_ps, input longint period_ps);
    longint c;
    c = (t_ps + period_ps - 1) / period_ps;
    if (c < 1) c = 1;
    return int'(c);
  endfunction

  // Clocks between AUTO REFRESH commands, rounded down, never below one.
  function automatic int refresh_interval_clk(input longint refresh_ms,
                                              input longint rows,
                                              input longint period_ps);
    longint c;
    c = (refresh_ms * longint'(1_000_000_000)) / (rows * period_ps);
    if (c < 1) c = 1;
    return int'(c);
  endfunction

  // Bits needed to hold value (at least one).
  function automatic int clog2_w(input longint value);
    int w;
    w = 1;
    while ((longint'(1) << w) <= value) w++;
    return w;
  endfunction

endpackage

// File: rtl/sdram_bank_timer.sv
// One SDRAM bank: IDLE/OPEN state plus tRCD, tRAS_min, tRC, tRAS_max and tRP
// down-counters. A counter at zero means its constraint is satisfied.
module sdram_bank_timer
  import sdram_timing_pkg::*;
#(
  parameter int T_RCD_CLK     = 2,
  parameter int T_RAS_MIN_CLK = 5,
  parameter int T_RC_CLK      = 7,
  parameter int T_RAS_MAX_CLK = 10000,
  parameter int T_RP_CLK      = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic act_cmd,
  input  logic pre_cmd,
  input  logic act_allow,
  output logic bank_open,
  output logic rdwr_ok,
  output logic pre_ok,
  output logic act_ok,
  output logic ras_expire,
  output logic cmd_err
);

  localparam int RCD_W = clog2_w(T_RCD_CLK - 1);
  localparam int RAS_W = clog2_w(T_RAS_MIN_CLK - 1);
  localparam int RC_W  = clog2_w(T_RC_CLK - 1);
  localparam int MAX_W = clog2_w(T_RAS_MAX_CLK - 1);
  localparam int RP_W  = clog2_w(T_RP_CLK - 1);

  // Loading T-1 makes the dependent command legal exactly T edges later.
  localparam logic [RCD_W-1:0] RCD_LOAD = RCD_W'(T_RCD_CLK - 1);
  localparam logic [RAS_W-1:0] RAS_LOAD = RAS_W'(T_RAS_MIN_CLK - 1);
  localparam logic [RC_W-1:0]  RC_LOAD  = RC_W'(T_RC_CLK - 1);
  localparam logic [MAX_W-1:0] MAX_LOAD = MAX_W'(T_RAS_MAX_CLK - 1);
  localparam logic [RP_W-1:0]  RP_LOAD  = RP_W'(T_RP_CLK - 1);

  bank_state_e      state_q, state_d;
  logic [RCD_W-1:0] rcd_q, rcd_d;
  logic [RAS_W-1:0] ras_q, ras_d;
  logic [RC_W-1:0]  rc_q, rc_d;
  logic [MAX_W-1:0] max_q, max_d;
  logic [RP_W-1:0]  rp_q, rp_d;

  assign bank_open  = (state_q == BANK_OPEN);
  assign rdwr_ok    = (rcd_q == '0);
  assign pre_ok     = (ras_q == '0);
  assign act_ok     = (state_q == BANK_IDLE) && (rp_q == '0) && (rc_q == '0) && act_allow;
  assign ras_expire = bank_open && (max_q == '0);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d = state_q;
    rcd_d   = (rcd_q == '0) ? rcd_q : rcd_q - 1'b1;
    ras_d   = (ras_q == '0) ? ras_q : ras_q - 1'b1;
    rc_d    = (rc_q  == '0) ? rc_q  : rc_q  - 1'b1;
    max_d   = (max_q == '0) ? max_q : max_q - 1'b1;
    rp_d    = (rp_q  == '0) ? rp_q  : rp_q  - 1'b1;
    cmd_err = (act_cmd && pre_cmd) || (act_cmd && !act_ok) || (pre_cmd && !pre_ok);

    // An illegal command only flags the error; the bank keeps its state.
    if (!cmd_err) begin
      if (act_cmd) begin
        state_d = BANK_OPEN;
        rcd_d   = RCD_LOAD;
        ras_d   = RAS_LOAD;
        rc_d    = RC_LOAD;
        max_d   = MAX_LOAD;
      end else if (pre_cmd) begin
        state_d = BANK_IDLE;
        rp_d    = RP_LOAD;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (!rstn) begin
      state_q <= BANK_IDLE;
      rcd_q   <= '0;
      ras_q   <= '0;
      rc_q    <= '0;
      max_q   <= '0;
      rp_q    <= '0;
    end else begin
      state_q <= state_d;
      rcd_q   <= rcd_d;
      ras_q   <= ras_d;
      rc_q    <= rc_d;
      max_q   <= max_d;
      rp_q    <= rp_d;
    end
  end

endmodule

// File: rtl/sdram_timing_mb.sv
// Multi-bank SDRAM timing monitor: per-bank timers plus tRFC and refresh credit.
// Define SDRAM_REFRESH_POSTPONE_EN to allow up to MAX_POSTPONE postponed refreshes.
module sdram_timing_mb
  import sdram_timing_pkg::*;
#(
  parameter int NUM_BANKS        = 4,
  parameter int SYSCLK_PERIOD_PS = 10000,
  parameter int T_RP_PS          = 20000,
  parameter int T_RCD_PS         = 20000,
  parameter int T_RAS_MIN_PS     = 44000,
  parameter int T_RC_PS          = 66000,
  parameter int T_RFC_PS         = 66000,
  parameter int T_RAS_MAX_PS     = 100000000,
  parameter int T_REFRESH_MS     = 64,
  parameter int REFRESH_ROWS     = 8192,
  parameter int MAX_POSTPONE     = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NUM_BANKS-1:0] act_cmd,
  input  logic [NUM_BANKS-1:0] pre_cmd,
  input  logic                 ref_cmd,
  output logic [NUM_BANKS-1:0] bank_open,
  output logic [NUM_BANKS-1:0] rdwr_ok,
  output logic [NUM_BANKS-1:0] pre_ok,
  output logic [NUM_BANKS-1:0] act_ok,
  output logic [NUM_BANKS-1:0] ras_expire,
  output logic                 ref_ok,
  output logic                 refresh_req,
  output logic                 refresh_urgent,
  output logic [CREDIT_W-1:0]  refresh_credit,
  output logic                 timing_err
);

  localparam int T_RCD_CLK     = ps_to_clk(T_RCD_PS, SYSCLK_PERIOD_PS);
  localparam int T_RAS_MIN_CLK = ps_to_clk(T_RAS_MIN_PS, SYSCLK_PERIOD_PS);
  localparam int T_RC_CLK      = ps_to_clk(T_RC_PS, SYSCLK_PERIOD_PS);
  localparam int T_RAS_MAX_CLK = ps_to_clk(T_RAS_MAX_PS, SYSCLK_PERIOD_PS);
  localparam int T_RP_CLK      = ps_to_clk(T_RP_PS, SYSCLK_PERIOD_PS);
  localparam int T_RFC_CLK     = ps_to_clk(T_RFC_PS, SYSCLK_PERIOD_PS);
  localparam int INTV_CLK      = refresh_interval_clk(T_REFRESH_MS, REFRESH_ROWS, SYSCLK_PERIOD_PS);

  localparam int RFC_W  = clog2_w(T_RFC_CLK - 1);
  localparam int INTV_W = clog2_w(INTV_CLK - 1);
  localparam logic [RFC_W-1:0]  RFC_LOAD  = RFC_W'(T_RFC_CLK - 1);
  localparam logic [INTV_W-1:0] INTV_LOAD = INTV_W'(INTV_CLK - 1);

`ifdef SDRAM_REFRESH_POSTPONE_EN
  localparam logic [CREDIT_W-1:0] CREDIT_CEIL = CREDIT_W'(MAX_POSTPONE);
`else
  localparam logic [CREDIT_W-1:0] CREDIT_CEIL = CREDIT_W'(1);
`endif

  if (NUM_BANKS < 1 || NUM_BANKS > 8 || MAX_POSTPONE < 1 || MAX_POSTPONE > 15) begin : g_bad_param
    $error("sdram_timing_mb: NUM_BANKS must be 1..8 and MAX_POSTPONE 1..15");
  end

  logic [NUM_BANKS-1:0] bank_err;
  logic                 rfc_done;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    sdram_bank_timer #(
      .T_RCD_CLK    (T_RCD_CLK),
      .T_RAS_MIN_CLK(T_RAS_MIN_CLK),
      .T_RC_CLK     (T_RC_CLK),
      .T_RAS_MAX_CLK(T_RAS_MAX_CLK),
      .T_RP_CLK     (T_RP_CLK)
    ) u_bank (
      .clk       (clk),
      .rstn      (rstn),
      .act_cmd   (act_cmd[b]),
      .pre_cmd   (pre_cmd[b]),
      .act_allow (rfc_done),
      .bank_open (bank_open[b]),
      .rdwr_ok   (rdwr_ok[b]),
      .pre_ok    (pre_ok[b]),
      .act_ok    (act_ok[b]),
      .ras_expire(ras_expire[b]),
      .cmd_err   (bank_err[b])
    );
  end

  logic [RFC_W-1:0]    rfc_q, rfc_d;
  logic [INTV_W-1:0]   intv_q, intv_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                err_q, err_d;
  logic                intv_term;
  logic                ref_go;

  assign rfc_done       = (rfc_q == '0);
  assign ref_ok         = (bank_open == '0) && (&act_ok) && rfc_done;
  assign intv_term      = (intv_q == '0);
  assign ref_go         = ref_cmd && ref_ok;
  assign refresh_credit = credit_q;
  assign refresh_req    = (credit_q != '0);
  assign timing_err     = err_q;

`ifdef SDRAM_REFRESH_POSTPONE_EN
  assign refresh_urgent = (credit_q == CREDIT_CEIL);
`else
  assign refresh_urgent = refresh_req;
`endif

  always_comb begin
    rfc_d    = ref_go ? RFC_LOAD : ((rfc_q == '0) ? rfc_q : rfc_q - 1'b1);
    intv_d   = intv_term ? INTV_LOAD : intv_q - 1'b1;
    credit_d = credit_q;
    err_d    = err_q || (|bank_err) || (ref_cmd && !ref_ok);

    // A refresh issued on the interval tick cancels that tick's new credit.
    unique case ({intv_term, ref_go})
      2'b10:   if (credit_q < CREDIT_CEIL) credit_d = credit_q + 1'b1;
      2'b01:   if (credit_q != '0)         credit_d = credit_q - 1'b1;
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rfc_q    <= '0;
      intv_q   <= INTV_LOAD;
      credit_q <= '0;
      err_q    <= 1'b0;
    end else begin
      rfc_q    <= rfc_d;
      intv_q   <= intv_d;
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

endmodule
